// File: rtl/fanout_pipe_buf.sv
// fanout_pipe_buf: DEPTH-stage elastic pipe feeding a NUM_LOADS-way fork (in_* producer side, out_* per-channel consumers sharing out_data, load_en channel enables, occupancy = valid stage count)
module fanout_pipe_buf #(
  parameter int WIDTH = 8,
  parameter int NUM_LOADS = 2,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  input  logic [NUM_LOADS-1:0]       load_en,
  output logic [NUM_LOADS-1:0]       out_valid,
  input  logic [NUM_LOADS-1:0]       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);
  localparam int L = DEPTH - 1;
  localparam int OW = $clog2(DEPTH + 1);
  logic [DEPTH-1:0] valid, adv, ld;
  logic [WIDTH-1:0] data [DEPTH];
  logic [WIDTH-1:0] src [DEPTH];
  logic [NUM_LOADS-1:0] done, fire;
  logic retire, in_fire, above_full;
  assign out_valid = {NUM_LOADS{valid[L]}} & load_en & ~done;
  assign fire = out_valid & out_ready;
  assign retire = valid[L] & (&(done | fire | ~load_en));
  assign out_data = data[L];
  assign in_ready = ~valid[0] | adv[0];
  assign in_fire = in_valid & in_ready;
  always_comb begin
    adv = '0;
    above_full = 1'b1;
    for (int k = L; k >= 0; k--) begin
      adv[k] = valid[k] & (retire | ~above_full);
      above_full = above_full & valid[k];
    end
  end
  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    if (g == 0) begin : g_head
      assign ld[g] = in_fire;
      assign src[g] = in_data;
    end else begin : g_body
      assign ld[g] = adv[g-1];
      assign src[g] = data[g-1];
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= '0;
      done <= '0;
      for (int k = 0; k < DEPTH; k++) data[k] <= '0;
    end else begin
      done <= retire ? '0 : done | ((fire | ~load_en) & {NUM_LOADS{valid[L]}});
      for (int k = 0; k < DEPTH; k++) begin
        valid[k] <= ld[k] | (valid[k] & ~adv[k]);
        if (ld[k]) data[k] <= src[k];
      end
    end
  end
  always_comb begin
    occupancy = '0;
    for (int k = 0; k < DEPTH; k++) occupancy = occupancy + OW'(valid[k]);
  end
endmodule

// File: doc/fanout_pipe_buf.md
FANOUT_PIPE_BUF -- requirements
Module: fanout_pipe_buf

Interface
REQ-001 Parameters, one per line (name, default, meaning):
- WIDTH, 8, data bits per item (1..64).
- NUM_LOADS, 2, fork output channels (1..8).
- DEPTH, 2, register stages between input and fork (1..4).

REQ-002 Ports, one per line (name, direction, width, meaning):
- clk, input, 1, sole clock; all state updates on rising edge.
- rst, input, 1, asynchronous active-high reset.
- in_valid, input, 1, producer offers item.
- in_ready, output, 1, block accepts item this cycle.
- in_data, input, WIDTH, item payload.
- load_en, input, NUM_LOADS, per-channel enable; disabled channel is never offered items.
- out_valid, output, NUM_LOADS, per-channel item offer.
- out_ready, input, NUM_LOADS, per-channel consumer acceptance.
- out_data, output, WIDTH, payload of the last stage, shared by all channels.
- occupancy, output, clog2(DEPTH+1), number of valid stages.

Function
REQ-003 Input transfer occurs iff in_valid and in_ready are both high at a rising edge; channel i transfer occurs iff out_valid[i] and out_ready[i] are both high.
REQ-004 Stages 0..DEPTH-1 each hold a valid bit and WIDTH data bits; stage 0 loads from in_data, stage k loads from stage k-1.
REQ-005 Stage k (k < DEPTH-1) advances when valid and (stage k+1 empty or stage k+1 advancing); the last stage retires when the fork completes (REQ-008).
REQ-006 in_ready = !valid[0] or stage 0 advancing; combinational, no dependence on in_valid.
REQ-007 Latency: an item accepted at edge T into an empty pipe appears on out_data/out_valid after edge T+DEPTH-1; with continuous ready, throughput is one item per cycle.
REQ-008 Fork: a per-channel done mask is maintained for the last-stage item; the item retires when (done | fire | ~load_en) is all ones, with fire[i] = out_valid[i] & out_ready[i].
REQ-009 out_valid[i] = valid[DEPTH-1] & load_en[i] & !done[i]; a channel fires at most once per item.
REQ-010 On retire the done mask clears to zero in the same edge; otherwise done |= fire.
REQ-011 load_en is sampled every cycle; a channel disabled while pending counts as done immediately; re-enabling a channel already done does not re-offer the item.
REQ-012 load_en all zero: the last-stage item retires in the cycle it becomes valid, with no out_valid asserted.
REQ-013 out_data = last-stage data; it is held stable while valid[DEPTH-1] is high and not retiring.
REQ-014 occupancy = count of set valid bits; increments on an input transfer without a retire, decrements on a retire without an input transfer, and is unchanged when both or neither occur.
REQ-015 Full: occupancy == DEPTH with the last stage not retiring forces in_ready low; simultaneous retire and input transfer when full is legal and occupancy stays at DEPTH.
REQ-016 DEPTH=1: in_ready = !valid[0] or retire, which gives a combinational ready path from out_ready to in_ready.

Reset
REQ-017 While rst is high, all valid bits, the done mask, all stage data, out_data and occupancy are 0; out_valid is 0 and in_ready is 1.
REQ-018 rst asserted mid-transfer discards all in-flight items asynchronously; no out_valid is asserted in the first cycle after release.
REQ-019 After release, operation resumes at the first rising edge with rst low.

Verification
REQ-020 The bench SHALL cover, at DEPTH=2, NUM_LOADS=2, WIDTH=8:
- Latency: push 0xA5 into an empty pipe, all out_ready high -> both out_valid high with out_data 0xA5 one cycle after acceptance (DEPTH-1 = 1); item retires the next edge; occupancy sequence 1,1,0.
- Skewed fork: out_ready = 01 then 10 -> ch0 fires cycle 1, ch1 fires cycle 2; out_valid[0] low in cycle 2; item retires once; no duplicate.
- Backpressure full: out_ready = 00, push 3 items -> third push sees in_ready low; occupancy 2; release ready -> order 1,2,3 preserved.
- Disable mid-item: ch1 pending, load_en -> 01 -> item retires the same edge; load_en = 00 -> items drain with out_valid never high.
- Simultaneous: full, retire plus push in the same cycle -> occupancy stays 2; no data loss.
- Reset mid-stream: assert rst with 2 items in flight -> occupancy 0, out_valid 0 immediately; a post-reset push of 0x3C is delivered intact.
